// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the 5-stage MIPS core: load-use stalls, wrong-path
// flushes on redirects, the exit-syscall halt/resume FSM and the statistics counters.
module pipeline_ctrl #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_r1_used,
   input  logic             id_r2_used,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_valid,
   input  logic             ex_mem_to_reg,
   input  logic [4:0]       ex_rd,
   input  logic             ex_jump,
   input  logic             ex_branch_taken,
   input  logic             ex_syscall,
   input  logic             ex_halt_req,
   input  logic             go,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] jump_cnt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int            DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   state_t           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] cycle_q, jump_q, branch_q, stall_q;
   logic             redirect_s, halt_s, lu_s, stall_sel_s;

   assign redirect_s = ex_valid & (ex_jump | ex_branch_taken);
   assign halt_s     = ex_valid & ex_syscall & ex_halt_req;
   assign lu_s       = ex_valid & ex_mem_to_reg & (ex_rd != 5'd0) &
                       ((id_r1_used & (id_rs == ex_rd)) | (id_r2_used & (id_rt == ex_rd)));

   // Next-state and control decode; reset forces the free-running control pattern
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      stall_sel_s = 1'b0;
      if (!rst_n) begin
         state_d = RUN;
         drain_d = {DW{1'b0}};
      end else begin
         case (state_q)
            RUN: begin
               if (halt_s) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  state_d    = DRAIN;
                  drain_d    = {DW{1'b0}};
               end else if (redirect_s) begin
                  // load-use is moot here: its consumer sits on the wrong path
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (lu_s) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_flush  = 1'b1;
                  stall_sel_s = 1'b1;
               end else begin
                  pc_en = 1'b1;
               end
            end
            DRAIN: begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (drain_q == DRAIN_LAST) begin
                  state_d = HALTED;
               end else begin
                  drain_d = drain_q + DW'(1);
               end
            end
            HALTED: begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (go) begin
                  state_d = RUN;
               end else begin
                  state_d = HALTED;
               end
            end
            default: begin
               state_d = RUN;
               drain_d = {DW{1'b0}};
            end
         endcase
      end
   end

   // State and statistics registers; event counters only advance in RUN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         drain_q  <= {DW{1'b0}};
         cycle_q  <= {CNT_W{1'b0}};
         jump_q   <= {CNT_W{1'b0}};
         branch_q <= {CNT_W{1'b0}};
         stall_q  <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         if (state_q != HALTED) cycle_q <= cycle_q + CNT_W'(1);
         if ((state_q == RUN) && ex_valid && ex_jump) jump_q <= jump_q + CNT_W'(1);
         if ((state_q == RUN) && ex_valid && ex_branch_taken) branch_q <= branch_q + CNT_W'(1);
         if (stall_sel_s) stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign halted     = rst_n & (state_q == HALTED);
   assign cycle_cnt  = rst_n ? cycle_q  : {CNT_W{1'b0}};
   assign jump_cnt   = rst_n ? jump_q   : {CNT_W{1'b0}};
   assign branch_cnt = rst_n ? branch_q : {CNT_W{1'b0}};
   assign stall_cnt  = rst_n ? stall_q  : {CNT_W{1'b0}};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (4-bit counters to exercise wrap):
// table of RUN-state vectors plus halt/resume/reset sequences, via a scoreboard queue.
module tb_pipeline_ctrl;

   localparam int CW = 4;

   typedef struct packed {
      logic       r1u;
      logic       r2u;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       exv;
      logic       m2r;
      logic [4:0] rd;
      logic       jmp;
      logic       brt;
      logic       sys;
      logic       hreq;
      logic       go;
   } in_t;

   typedef struct {
      in_t         in;
      logic [3:0]  ctrl;
      string       name;
   } vec_t;

   typedef struct {
      string       name;
      logic [4:0]  ctrl;
      logic [15:0] cnts;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic id_r1_used, id_r2_used, ex_valid, ex_mem_to_reg, ex_jump, ex_branch_taken;
   logic ex_syscall, ex_halt_req, go;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic pc_en, ifid_en, ifid_flush, idex_flush, halted;
   logic [CW-1:0] cycle_cnt, jump_cnt, branch_cnt, stall_cnt;

   int total = 0;
   int bad   = 0;
   rec_t sb[$];
   vec_t tbl[$];
   logic [CW-1:0] m_cyc, m_jmp, m_br, m_st;

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(CW), .DRAIN_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_rs(id_rs), .id_rt(id_rt),
      .ex_valid(ex_valid), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
      .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken), .ex_syscall(ex_syscall),
      .ex_halt_req(ex_halt_req), .go(go),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .halted(halted), .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt),
      .branch_cnt(branch_cnt), .stall_cnt(stall_cnt)
   );

   // Scoreboard checker: compare each pending expectation mid-cycle
   always @(negedge clk) begin
      rec_t r;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         total++;
         if ({pc_en, ifid_en, ifid_flush, idex_flush, halted} !== r.ctrl) begin
            bad++;
            $display("FAIL %s ctrl {pc,ifid_en,ifid_fl,idex_fl,halted} got %b want %b",
                     r.name, {pc_en, ifid_en, ifid_flush, idex_flush, halted}, r.ctrl);
         end
         total++;
         if ({cycle_cnt, jump_cnt, branch_cnt, stall_cnt} !== r.cnts) begin
            bad++;
            $display("FAIL %s counters {cyc,jmp,br,st} got %h want %h",
                     r.name, {cycle_cnt, jump_cnt, branch_cnt, stall_cnt}, r.cnts);
         end
      end
   end

   function automatic in_t mk(bit r1u, bit r2u, int rs, int rt, bit exv, bit m2r, int rd,
                              bit j, bit b, bit s, bit h, bit g);
      in_t v;
      v.r1u = r1u; v.r2u = r2u; v.rs = rs[4:0]; v.rt = rt[4:0];
      v.exv = exv; v.m2r = m2r; v.rd = rd[4:0];
      v.jmp = j; v.brt = b; v.sys = s; v.hreq = h; v.go = g;
      return v;
   endfunction

   task automatic apply(input in_t v);
      id_r1_used = v.r1u; id_r2_used = v.r2u; id_rs = v.rs; id_rt = v.rt;
      ex_valid = v.exv; ex_mem_to_reg = v.m2r; ex_rd = v.rd;
      ex_jump = v.jmp; ex_branch_taken = v.brt; ex_syscall = v.sys;
      ex_halt_req = v.hreq; go = v.go;
   endtask

   task automatic add(input in_t v, input logic [3:0] c, input string n);
      vec_t t;
      t.in = v; t.ctrl = c; t.name = n;
      tbl.push_back(t);
   endtask

   // One clock: drive, expect, then advance the counter model across the edge
   task automatic cyc(input in_t v, input logic [3:0] c, input logic h, input logic run,
                      input string n);
      rec_t r;
      apply(v);
      r.name = n;
      r.ctrl = {c, h};
      r.cnts = {m_cyc, m_jmp, m_br, m_st};
      sb.push_back(r);
      @(negedge clk);
      if (!h) m_cyc = m_cyc + 4'd1;
      if (run && v.exv && v.jmp) m_jmp = m_jmp + 4'd1;
      if (run && v.exv && v.brt) m_br = m_br + 4'd1;
      if (run && c == 4'b0001) m_st = m_st + 4'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input in_t junk, input string n);
      rec_t r;
      rst_n = 1'b0;
      apply(junk);
      r.name = n;
      r.ctrl = 5'b11000;
      r.cnts = 16'h0000;
      sb.push_back(r);
      @(negedge clk);
      @(posedge clk);
      #1;
      m_cyc = 4'd0; m_jmp = 4'd0; m_br = 4'd0; m_st = 4'd0;
      rst_n = 1'b1;
   endtask

   initial begin
      in_t nop, hlt, junk, lw_use;
      nop    = mk(0,0,0,0, 0,0,0, 0,0,0,0,0);
      hlt    = mk(0,0,0,0, 1,0,0, 0,0,1,1,0);
      junk   = mk(1,0,8,0, 1,1,8, 1,0,0,0,1);
      lw_use = mk(1,0,8,0, 1,1,8, 0,0,0,0,0);

      add(nop,                                4'b1100, "idle");
      add(lw_use,                             4'b0001, "lu_rs");
      add(nop,                                4'b1100, "lu_cleared");
      add(mk(1,0,0,0, 1,1,0, 0,0,0,0,0),      4'b1100, "lu_rd0");
      add(mk(0,0,8,0, 1,1,8, 0,0,0,0,0),      4'b1100, "lu_no_r1");
      add(mk(0,1,3,8, 1,1,8, 0,0,0,0,0),      4'b0001, "lu_rt");
      add(mk(1,0,8,0, 0,1,8, 0,0,0,0,0),      4'b1100, "lu_exv0");
      add(mk(1,1,9,7, 1,1,8, 0,0,0,0,0),      4'b1100, "lu_reg_miss");
      add(mk(1,0,8,0, 1,1,8, 0,1,0,0,0),      4'b1111, "branch_over_lu");
      add(mk(0,0,0,0, 1,0,0, 1,0,0,0,0),      4'b1111, "jr");
      add(mk(0,0,0,0, 1,0,0, 1,0,0,0,0),      4'b1111, "j");
      add(mk(0,0,0,0, 0,0,0, 1,0,0,0,0),      4'b1100, "jump_exv0");
      add(mk(0,0,0,0, 1,0,0, 0,0,1,0,0),      4'b1100, "syscall_noexit");
      add(mk(0,0,0,0, 0,0,0, 0,0,0,0,1),      4'b1100, "go_in_run");

      do_reset(junk, "reset_initial");
      for (int k = 0; k < tbl.size(); k++) cyc(tbl[k].in, tbl[k].ctrl, 1'b0, 1'b1, tbl[k].name);

      // halt timeline: halt at T, DRAIN T+1..T+2 (inputs ignored), HALTED from T+3
      cyc(hlt,  4'b0011, 1'b0, 1'b1, "halt_cycle");
      cyc(junk, 4'b0011, 1'b0, 1'b0, "drain1");
      cyc(junk, 4'b0011, 1'b0, 1'b0, "drain2");
      for (int k = 0; k < 3; k++) cyc(lw_use, 4'b0011, 1'b1, 1'b0, "halted_frozen");
      cyc(junk, 4'b0011, 1'b1, 1'b0, "halted_go");
      cyc(mk(0,0,0,0, 0,0,0, 0,0,0,0,1), 4'b1100, 1'b0, 1'b1, "resume_go_held");
      cyc(mk(0,0,0,0, 0,0,0, 0,0,0,0,1), 4'b1100, 1'b0, 1'b1, "go_held_run");
      cyc(lw_use, 4'b0001, 1'b0, 1'b1, "lu_after_resume");

      // reset while halted
      cyc(hlt, 4'b0011, 1'b0, 1'b1, "halt2");
      cyc(nop, 4'b0011, 1'b0, 1'b0, "drain2_1");
      cyc(nop, 4'b0011, 1'b0, 1'b0, "drain2_2");
      cyc(nop, 4'b0011, 1'b1, 1'b0, "halted2");
      do_reset(hlt, "reset_mid_halt");

      // wrap: 17 RUN cycles from reset release leave cycle_cnt at 1
      for (int k = 0; k < 17; k++) cyc(nop, 4'b1100, 1'b0, 1'b1, "wrap_run");
      apply(nop);
      @(negedge clk);
      total++;
      if (cycle_cnt !== 4'd1) begin
         bad++;
         $display("FAIL wrap cycle_cnt got %0d want 1", cycle_cnt);
      end
      @(posedge clk);
      #1;

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain pending got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
